// File: rtl/logicnet_pkg.sv
// Shared constants for the LogicNet layer sequencer.
//   MAX_LAYERS    : largest supported number of registered layer boundaries
//   OCC_W         : width of the occupancy count (holds 0..MAX_LAYERS)
//   CNT_W_DEFAULT : default width of the stall performance counter
package logicnet_pkg;

  localparam int unsigned MAX_LAYERS    = 16;
  localparam int unsigned OCC_W         = 5;
  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/logicnet_stage_ctrl.sv
// Valid flag and advance logic for one layer boundary of the LUT-neuron pipeline.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   i_block  : suppress all advances and clear the flag (reset or flush)
//   i_up_vld : predecessor holds a valid vector (s_valid for stage 0)
//   i_dn_go  : successor takes this stage's vector this cycle (m_ready for last stage)
//   o_adv    : this stage loads a new vector this cycle (drives stage_en)
//   o_vld    : this stage holds a valid vector
module logicnet_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic i_block,
  input  logic i_up_vld,
  input  logic i_dn_go,
  output logic o_adv,
  output logic o_vld
);

  logic r_vld;
  logic w_adv;

  // Load when something is offered and the slot is empty or being vacated.
  assign w_adv = i_up_vld && (!r_vld || i_dn_go) && !i_block;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (i_block) begin
      r_vld <= 1'b0;
    end else if (w_adv) begin
      r_vld <= 1'b1;
    end else if (i_dn_go) begin
      // Emptied downstream with no refill.
      r_vld <= 1'b0;
    end
  end

  assign o_adv = w_adv;
  assign o_vld = r_vld;

endmodule

// File: rtl/logicnet_layer_seq.sv
// Handshake sequencer for a LAYERS-deep registered LUT-neuron pipeline. Holds no data,
// only per-stage valid flags; the datapath registers outside load on stage_en.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   s_valid    : upstream vector valid;        s_ready : vector accepted this cycle
//   m_valid    : last stage holds a result;    m_ready : downstream consumes it
//   flush      : discard every in-flight vector
//   stage_en   : per-stage load enables (bit 0 captures the input vector)
//   stage_vld  : per-stage valid flags
//   occupancy  : number of valid stages
//   stall_cnt  : saturating count of m_valid && !m_ready cycles
module logicnet_layer_seq
  import logicnet_pkg::*;
#(
  parameter int unsigned LAYERS = 4,
  parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  output logic [LAYERS-1:0] stage_en,
  output logic [LAYERS-1:0] stage_vld,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_block;
  logic [LAYERS-1:0] w_vld;
  logic [LAYERS-1:0] w_adv;
  logic [LAYERS-1:0] w_up_vld;
  logic [LAYERS-1:0] w_dn_go;
  logic              w_go;
  logic              w_accept;
  logic              w_emit;
  logic [OCC_W-1:0]  r_occ;
  logic [CNT_W-1:0]  r_stall;

  assign w_block = rst || flush;

  always_comb begin
    w_up_vld[0] = s_valid;
    for (int i = 1; i < LAYERS; i++) begin
      w_up_vld[i] = w_vld[i-1];
    end
  end

  // Downstream-go chain, rippled from the output back toward stage 0. Built only from
  // the registered flags (never s_valid), so s_ready has no path from s_valid. It
  // recomputes each successor's advance term here in one block rather than feeding the
  // stage outputs back, which keeps the ripple free of combinational feedback.
  always_comb begin
    w_go = m_ready;
    for (int i = LAYERS - 1; i > 0; i--) begin
      w_dn_go[i] = w_go;
      w_go       = w_vld[i-1] && (!w_vld[i] || w_go) && !w_block;
    end
    w_dn_go[0] = w_go;
  end

  for (genvar g = 0; g < LAYERS; g++) begin : g_stage
    logicnet_stage_ctrl u_stage (
      .clk      (clk),
      .rst      (rst),
      .i_block  (w_block),
      .i_up_vld (w_up_vld[g]),
      .i_dn_go  (w_dn_go[g]),
      .o_adv    (w_adv[g]),
      .o_vld    (w_vld[g])
    );
  end

  assign s_ready  = !w_block && (!w_vld[0] || w_dn_go[0]);
  // Masked during reset so an in-flight result is never presented while dropping it.
  assign m_valid  = w_vld[LAYERS-1] && !rst;
  assign w_accept = w_adv[0];
  assign w_emit   = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_occ <= '0;
    end else if (w_accept && !w_emit) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (w_emit && !w_accept) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  // Survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (m_valid && !m_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign stage_en  = w_adv;
  assign stage_vld = w_vld;
  assign occupancy = r_occ;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_logicnet_layer_seq.sv
module tb_logicnet_layer_seq;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        m_ready;
  logic        flush;
  logic        s_ready;
  logic        m_valid;
  logic [3:0]  stage_en;
  logic [3:0]  stage_vld;
  logic [4:0]  occupancy;
  logic [15:0] stall_cnt;

  // Second instance with a 4-bit counter shares the stimulus to exercise saturation.
  logic        s_ready4;
  logic        m_valid4;
  logic [3:0]  stage_en4;
  logic [3:0]  stage_vld4;
  logic [4:0]  occupancy4;
  logic [3:0]  stall_cnt4;

  int n_vec;
  int n_err;
  int acc;

  logicnet_layer_seq #(.LAYERS(4), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .flush     (flush),
    .stage_en  (stage_en),
    .stage_vld (stage_vld),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  logicnet_layer_seq #(.LAYERS(4), .CNT_W(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready4),
    .m_valid   (m_valid4),
    .m_ready   (m_ready),
    .flush     (flush),
    .stage_en  (stage_en4),
    .stage_vld (stage_vld4),
    .occupancy (occupancy4),
    .stall_cnt (stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; flush = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_vld", 32'(stage_vld), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_en", 32'(stage_en), 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // Single vector walks the pipe
    s_valid = 1'b1; m_ready = 1'b1; #1;
    chk("walk_en0", 32'(stage_en), 32'h1);
    tick(); s_valid = 1'b0; #1;
    chk("walk_en1", 32'(stage_en), 32'h2);
    chk("walk_mv1", 32'(m_valid), 32'd0);
    chk("walk_occ1", 32'(occupancy), 32'd1);
    tick(); #1;
    chk("walk_en2", 32'(stage_en), 32'h4);
    tick(); #1;
    chk("walk_en3", 32'(stage_en), 32'h8);
    chk("walk_mv3", 32'(m_valid), 32'd0);
    tick(); #1;
    chk("walk_mv4", 32'(m_valid), 32'd1);
    chk("walk_en4", 32'(stage_en), 32'h0);
    tick(); #1;
    chk("walk_mv5", 32'(m_valid), 32'd0);
    chk("walk_occ5", 32'(occupancy), 32'd0);

    // Streaming at full rate
    s_valid = 1'b1; m_ready = 1'b1; acc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("stream_mv", 32'(m_valid), (k >= 4) ? 32'd1 : 32'd0);
      chk("stream_occ", 32'(occupancy), (k < 4) ? 32'(k) : 32'd4);
      if (s_valid && s_ready) acc++;
      tick();
    end
    chk("stream_accepts", 32'(acc), 32'd20);
    s_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("stream_drained", 32'(stage_vld), 32'd0);
    chk("stream_no_stall", 32'(stall_cnt), 32'd0);

    // Full pipe stalled by downstream
    s_valid = 1'b1; m_ready = 1'b0;
    repeat (4) tick();
    #1;
    chk("stall_full", 32'(stage_vld), 32'hf);
    for (int k = 0; k < 10; k++) begin
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_en", 32'(stage_en), 32'd0);
      tick(); #1;
    end
    chk("stall_cnt10", 32'(stall_cnt), 32'd10);
    chk("stall_cnt10_w4", 32'(stall_cnt4), 32'd10);
    chk("stall_occ", 32'(occupancy), 32'd4);
    m_ready = 1'b1; #1;
    chk("release_s_ready", 32'(s_ready), 32'd1);
    chk("release_en", 32'(stage_en), 32'hf);
    tick(); #1;
    chk("release_occ", 32'(occupancy), 32'd4);
    chk("release_stall", 32'(stall_cnt), 32'd10);
    s_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("release_drained", 32'(stage_vld), 32'd0);
    chk("release_occ0", 32'(occupancy), 32'd0);

    // Bubble collapse: build vld=1010 with m_ready held low
    m_ready = 1'b0; s_valid = 1'b1; #1;
    tick(); s_valid = 1'b0; #1;
    chk("bub_vld_0001", 32'(stage_vld), 32'h1);
    tick(); s_valid = 1'b1; #1;
    chk("bub_vld_0010", 32'(stage_vld), 32'h2);
    tick(); s_valid = 1'b0; #1;
    chk("bub_vld_0101", 32'(stage_vld), 32'h5);
    tick(); s_valid = 1'b1; #1;
    chk("bub_vld_1010", 32'(stage_vld), 32'ha);
    chk("bub_en", 32'(stage_en), 32'h5);
    chk("bub_s_ready", 32'(s_ready), 32'd1);
    tick(); #1;
    chk("bub_vld_1101", 32'(stage_vld), 32'hd);
    chk("bub_occ", 32'(occupancy), 32'd3);
    chk("bub_stall", 32'(stall_cnt), 32'd11);

    // Flush with three valid stages
    s_valid = 1'b0; flush = 1'b1; #1;
    chk("flush_s_ready", 32'(s_ready), 32'd0);
    chk("flush_en", 32'(stage_en), 32'd0);
    tick(); flush = 1'b0; #1;
    chk("flush_vld", 32'(stage_vld), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_mv", 32'(m_valid), 32'd0);
    chk("flush_stall", 32'(stall_cnt), 32'd12);
    chk("flush_stall_w4", 32'(stall_cnt4), 32'd12);
    tick(); #1;
    chk("flush_mv_after", 32'(m_valid), 32'd0);

    // Long stall: 4-bit counter saturates, then reset mid-operation
    s_valid = 1'b1; m_ready = 1'b0; #1;
    tick(); s_valid = 1'b0;
    repeat (3) tick();
    #1;
    chk("sat_mv", 32'(m_valid), 32'd1);
    repeat (20) tick();
    #1;
    chk("sat_stall16", 32'(stall_cnt), 32'd32);
    chk("sat_stall4", 32'(stall_cnt4), 32'd15);
    chk("sat_mv_hold", 32'(m_valid), 32'd1);
    rst = 1'b1; #1;
    chk("midrst_mv", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_en", 32'(stage_en), 32'd0);
    tick(); rst = 1'b0; #1;
    chk("after_rst_stall16", 32'(stall_cnt), 32'd0);
    chk("after_rst_stall4", 32'(stall_cnt4), 32'd0);
    chk("after_rst_vld", 32'(stage_vld), 32'd0);
    chk("after_rst_occ", 32'(occupancy), 32'd0);
    chk("after_rst_mv", 32'(m_valid), 32'd0);
    chk("after_rst_s_ready", 32'(s_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
